irrigation_pump_ctrl: RTL and testbench

Downstream consumer of the soil moisture sensor's 8-bit moisture_percentage output. Samples the reading at a fixed rate, clamps it to 0..100, and averages it over 4 samples. A hysteresis state machine then drives the pump/valve with a minimum run time, a watchdog run limit, and a cooldown period. It also supports a manual watering request and latches a fault when the soil never reaches the wet threshold.

---
 rtl/irrigation_pkg.sv | 17 +
 rtl/moisture_avg_filter.sv | 54 +++++
 rtl/irrigation_pump_ctrl.sv | 141 ++++++++++++++
 tb/tb_irrigation_pump_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation pump controller.
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WATERING = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_FAULT    = 2'd3
    } pump_state_t;

    localparam int unsigned MOISTURE_W   = 8;
    localparam int unsigned MOISTURE_MAX = 100;
    localparam int unsigned AVG_DEPTH    = 4;
    localparam int unsigned AVG_SHIFT    = 2;
    localparam int unsigned SUM_W        = 10;

endpackage

// File: rtl/moisture_avg_filter.sv
// Clamps moisture samples to 0..100 and keeps a 4-sample moving average.
module moisture_avg_filter
    import irrigation_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_stb,
    input  logic [MOISTURE_W-1:0] moisture_percentage,
    output logic [MOISTURE_W-1:0] avg_moisture,
    output logic                  avg_valid
);

    localparam int unsigned FILL_W = $clog2(AVG_DEPTH + 1);

    logic [MOISTURE_W-1:0] clamped;
    logic [MOISTURE_W-1:0] sample_q [AVG_DEPTH];
    logic [SUM_W-1:0]      sum_q;
    logic [SUM_W-1:0]      sum_d;
    logic [FILL_W-1:0]     fill_q;

    // Clamp the input and form the running sum with the oldest sample retired.
    always_comb begin
        clamped = (moisture_percentage > MOISTURE_W'(MOISTURE_MAX))
                  ? MOISTURE_W'(MOISTURE_MAX) : moisture_percentage;
        sum_d   = sum_q + SUM_W'(clamped) - SUM_W'(sample_q[AVG_DEPTH-1]);
    end

    // Shift buffer, sum, average and fill tracking, updated once per sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < AVG_DEPTH; i++) begin
                sample_q[i] <= '0;
            end
            sum_q        <= '0;
            fill_q       <= '0;
            avg_moisture <= '0;
            avg_valid    <= 1'b0;
        end else if (sample_stb) begin
            sample_q[0] <= clamped;
            for (int unsigned i = 1; i < AVG_DEPTH; i++) begin
                sample_q[i] <= sample_q[i-1];
            end
            sum_q        <= sum_d;
            avg_moisture <= MOISTURE_W'(sum_d >> AVG_SHIFT);
            if (fill_q != FILL_W'(AVG_DEPTH)) begin
                fill_q <= fill_q + FILL_W'(1);
            end
            if (fill_q >= FILL_W'(AVG_DEPTH - 1)) begin
                avg_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_pump_ctrl.sv
// Pump/valve controller: sample divider, moisture filter and hysteresis FSM
// with minimum run time, watchdog limit, cooldown and manual runs.
module irrigation_pump_ctrl
    import irrigation_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV       = 1000,
    parameter int unsigned DRY_THRESH       = 30,
    parameter int unsigned WET_THRESH       = 60,
    parameter int unsigned MIN_RUN_SAMPLES  = 3,
    parameter int unsigned MAX_RUN_SAMPLES  = 8,
    parameter int unsigned COOLDOWN_SAMPLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] moisture_percentage,
    input  logic       enable,
    input  logic       manual_req,
    input  logic       fault_clr,
    output logic       pump_on,
    output logic       fault,
    output logic [1:0] state,
    output logic [7:0] avg_moisture,
    output logic       avg_valid
);

    localparam int unsigned DIV_W   = $clog2(SAMPLE_DIV);
    localparam int unsigned CNT_MAX = (MAX_RUN_SAMPLES > COOLDOWN_SAMPLES)
                                      ? MAX_RUN_SAMPLES : COOLDOWN_SAMPLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [DIV_W-1:0] div_q;
    logic             sample_stb;
    logic             eval_stb_q;
    pump_state_t      state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, cnt_inc;
    logic             manual_q, manual_d;

    // Sample-rate divider; eval strobe trails the sample strobe by one cycle
    // so the FSM sees the freshly updated average.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            eval_stb_q <= 1'b0;
        end else begin
            div_q      <= sample_stb ? '0 : div_q + DIV_W'(1);
            eval_stb_q <= sample_stb;
        end
    end

    assign sample_stb = (div_q == DIV_W'(SAMPLE_DIV - 1));

    moisture_avg_filter u_filter (
        .clk                 (clk),
        .reset               (reset),
        .sample_stb          (sample_stb),
        .moisture_percentage (moisture_percentage),
        .avg_moisture        (avg_moisture),
        .avg_valid           (avg_valid)
    );

    // State register with registered pump/fault decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= '0;
            manual_q  <= 1'b0;
            pump_on   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            manual_q  <= manual_d;
            pump_on   <= (state_d == ST_WATERING);
            fault     <= (state_d == ST_FAULT);
        end
    end

    // Next-state logic; run_cnt doubles as the cooldown counter and saturates.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        manual_d  = manual_q;
        cnt_inc   = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (manual_req && enable) begin
                    state_d   = ST_WATERING;
                    run_cnt_d = '0;
                    manual_d  = 1'b1;
                end else if (eval_stb_q && enable && avg_valid &&
                             (avg_moisture < 8'(DRY_THRESH))) begin
                    state_d   = ST_WATERING;
                    run_cnt_d = '0;
                    manual_d  = 1'b0;
                end
            end
            ST_WATERING: begin
                if (!enable) begin
                    state_d   = ST_COOLDOWN;
                    run_cnt_d = '0;
                end else if (eval_stb_q) begin
                    run_cnt_d = cnt_inc;
                    if (manual_q) begin
                        if (cnt_inc >= CNT_W'(MIN_RUN_SAMPLES)) begin
                            state_d   = ST_COOLDOWN;
                            run_cnt_d = '0;
                        end
                    end else if ((cnt_inc >= CNT_W'(MIN_RUN_SAMPLES)) &&
                                 (avg_moisture >= 8'(WET_THRESH))) begin
                        state_d   = ST_COOLDOWN;
                        run_cnt_d = '0;
                    end else if (cnt_inc >= CNT_W'(MAX_RUN_SAMPLES)) begin
                        state_d   = ST_FAULT;
                        run_cnt_d = '0;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (eval_stb_q) begin
                    run_cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_W'(COOLDOWN_SAMPLES)) begin
                        state_d   = ST_IDLE;
                        run_cnt_d = '0;
                        manual_d  = 1'b0;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d   = ST_IDLE;
                    run_cnt_d = '0;
                    manual_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_irrigation_pump_ctrl.sv
// Scoreboard bench for irrigation_pump_ctrl with a short sample period.
module tb_irrigation_pump_ctrl;

    localparam int unsigned SAMPLE_DIV = 4;

    typedef struct packed {
        logic [7:0] avg;
        logic       valid;
        logic [1:0] st;
        logic       pump;
        logic       flt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] moisture_percentage;
    logic       enable;
    logic       manual_req;
    logic       fault_clr;
    logic       pump_on;
    logic       fault;
    logic [1:0] state;
    logic [7:0] avg_moisture;
    logic       avg_valid;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    irrigation_pump_ctrl #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
        .clk                 (clk),
        .reset               (reset),
        .moisture_percentage (moisture_percentage),
        .enable              (enable),
        .manual_req          (manual_req),
        .fault_clr           (fault_clr),
        .pump_on             (pump_on),
        .fault               (fault),
        .state               (state),
        .avg_moisture        (avg_moisture),
        .avg_valid           (avg_valid)
    );

    always #5 clk = ~clk;

    // Edges since reset release; evaluations land on cyc = 4k+1.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    function automatic obs_t sample_obs();
        return {avg_moisture, avg_valid, state, pump_on, fault};
    endfunction

    function automatic void push_exp(input logic [7:0] a, input logic v,
                                     input logic [1:0] s, input logic p, input logic f);
        exp_q.push_back({a, v, s, p, f});
    endfunction

    // Advance to just after the next evaluation edge (bounded).
    task automatic wait_eval(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * int'(SAMPLE_DIV); i++) begin
            @(posedge clk);
            #1;
            if ((cyc % int'(SAMPLE_DIV) == 1) && (cyc > 1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [7:0] m);
        reset = 1'b1; enable = 1'b1; manual_req = 1'b0; fault_clr = 1'b0;
        moisture_percentage = m;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o; bit ok;
        reset = 1'b1; enable = 1'b1; manual_req = 1'b0; fault_clr = 1'b0;
        moisture_percentage = 8'd50;
        repeat (2) @(posedge clk);
        #1;
        push_exp(8'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = sample_obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", o, e);
        end
        reset = 1'b0;
        push_exp(8'd12, 1'b0, 2'd0, 1'b0, 1'b0);
        push_exp(8'd25, 1'b0, 2'd0, 1'b0, 1'b0);
        push_exp(8'd37, 1'b0, 2'd0, 1'b0, 1'b0);
        push_exp(8'd50, 1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_eval(ok);
            e = exp_q.pop_front(); o = sample_obs(); vectors++;
            if (!ok || o !== e) begin
                miscompares++;
                $display("FAIL fill50_eval%0d: got %h want %h (sync %0b)", i + 1, o, e, ok);
            end
        end
    endtask

    task automatic test_auto_cycle();
        obs_t e, o; bit ok;
        logic [7:0] avgs [10] = '{8'd5, 8'd10, 8'd15, 8'd20, 8'd32, 8'd45, 8'd57, 8'd70, 8'd70, 8'd70};
        logic [1:0] sts  [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        do_reset(8'd20);
        for (int i = 0; i < 10; i++) begin
            push_exp(avgs[i], (i >= 3), sts[i], (sts[i] == 2'd1), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            wait_eval(ok);
            if (i == 3) moisture_percentage = 8'd70;
            e = exp_q.pop_front(); o = sample_obs(); vectors++;
            if (!ok || o !== e) begin
                miscompares++;
                $display("FAIL auto_eval%0d: got %h want %h (sync %0b)", i + 1, o, e, ok);
            end
        end
    endtask

    task automatic test_fault();
        obs_t e, o; bit ok;
        do_reset(8'd20);
        for (int i = 0; i < 3; i++) wait_eval(ok);
        for (int i = 4; i <= 12; i++) begin
            if (i < 12) push_exp(8'd20, 1'b1, 2'd1, 1'b1, 1'b0);
            else        push_exp(8'd20, 1'b1, 2'd3, 1'b0, 1'b1);
        end
        for (int i = 4; i <= 12; i++) begin
            wait_eval(ok);
            e = exp_q.pop_front(); o = sample_obs(); vectors++;
            if (!ok || o !== e) begin
                miscompares++;
                $display("FAIL watchdog_eval%0d: got %h want %h (sync %0b)", i, o, e, ok);
            end
        end
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        push_exp(8'd20, 1'b1, 2'd0, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = sample_obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL fault_clr: got %h want %h", o, e);
        end
        push_exp(8'd20, 1'b1, 2'd1, 1'b1, 1'b0);
        wait_eval(ok);
        e = exp_q.pop_front(); o = sample_obs(); vectors++;
        if (!ok || o !== e) begin
            miscompares++;
            $display("FAIL restart_after_clr: got %h want %h (sync %0b)", o, e, ok);
        end
    endtask

    task automatic test_clamp();
        obs_t e, o; bit ok;
        do_reset(8'd200);
        push_exp(8'd25,  1'b0, 2'd0, 1'b0, 1'b0);
        push_exp(8'd50,  1'b0, 2'd0, 1'b0, 1'b0);
        push_exp(8'd75,  1'b0, 2'd0, 1'b0, 1'b0);
        push_exp(8'd100, 1'b1, 2'd0, 1'b0, 1'b0);
        push_exp(8'd100, 1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_eval(ok);
            if (i == 3) moisture_percentage = 8'd255;
            e = exp_q.pop_front(); o = sample_obs(); vectors++;
            if (!ok || o !== e) begin
                miscompares++;
                $display("FAIL clamp_eval%0d: got %h want %h (sync %0b)", i + 1, o, e, ok);
            end
        end
    endtask

    task automatic test_enable_drop();
        obs_t e, o; bit ok;
        do_reset(8'd20);
        for (int i = 0; i < 4; i++) wait_eval(ok);
        enable = 1'b0;
        @(posedge clk); #1;
        push_exp(8'd20, 1'b1, 2'd2, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = sample_obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL enable_drop: got %h want %h", o, e);
        end
        enable = 1'b1;
        manual_req = 1'b1;
        @(posedge clk); #1;
        manual_req = 1'b0;
        push_exp(8'd20, 1'b1, 2'd2, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = sample_obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL manual_in_cooldown: got %h want %h", o, e);
        end
        push_exp(8'd20, 1'b1, 2'd2, 1'b0, 1'b0);
        push_exp(8'd20, 1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wait_eval(ok);
            e = exp_q.pop_front(); o = sample_obs(); vectors++;
            if (!ok || o !== e) begin
                miscompares++;
                $display("FAIL cooldown_eval%0d: got %h want %h (sync %0b)", i + 1, o, e, ok);
            end
        end
    endtask

    task automatic test_manual();
        obs_t e, o; bit ok;
        logic [1:0] sts [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        do_reset(8'd50);
        for (int i = 0; i < 4; i++) wait_eval(ok);
        manual_req = 1'b1;
        @(posedge clk); #1;
        manual_req = 1'b0;
        push_exp(8'd50, 1'b1, 2'd1, 1'b1, 1'b0);
        e = exp_q.pop_front(); o = sample_obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL manual_start: got %h want %h", o, e);
        end
        for (int i = 0; i < 5; i++) push_exp(8'd50, 1'b1, sts[i], (sts[i] == 2'd1), 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_eval(ok);
            e = exp_q.pop_front(); o = sample_obs(); vectors++;
            if (!ok || o !== e) begin
                miscompares++;
                $display("FAIL manual_eval%0d: got %h want %h (sync %0b)", i + 1, o, e, ok);
            end
        end
        manual_req = 1'b1;
        @(posedge clk); #1;
        manual_req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        push_exp(8'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = sample_obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_mid_run: got %h want %h", o, e);
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_auto_cycle();
        test_fault();
        test_clamp();
        test_enable_drop();
        test_manual();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
